// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory port.
// Exactly one transaction is in flight: IDLE accepts, ISSUE strobes memory,
// WAIT captures the registered memory response, RESP holds it for the owner.
module mem_arbiter #(
  parameter int _W = 32,
  parameter int _D = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [_W-1:0] p0_wdat,
  output logic          p0_rvalid,
  input  logic          p0_rready,
  output logic [_W-1:0] p0_rdat,
  output logic          p0_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [_W-1:0] p1_wdat,
  output logic          p1_rvalid,
  input  logic          p1_rready,
  output logic [_W-1:0] p1_rdat,
  output logic          p1_err,
  output logic          mem_read_en,
  output logic          mem_write_en,
  output logic [31:0]   mem_read_addr,
  output logic [31:0]   mem_write_addr,
  output logic [_W-1:0] mem_write_dat,
  input  logic [_W-1:0] mem_read_dat,
  input  logic          mem_r_v,
  input  logic          mem_w_v
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Addresses at or above the depth never reach the memory.
  localparam logic [32:0] ADDR_LIMIT = 33'(_D);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [_W-1:0] wdat_q, wdat_d;
  logic [_W-1:0] rdat_q, rdat_d;
  logic          err_q, err_d;

  logic          grant_s;
  logic          any_valid_s;
  logic [31:0]   sel_addr_s;
  logic          ready0_s, ready1_s;
  logic          rd_en_s, wr_en_s;
  logic [31:0]   rd_addr_s, wr_addr_s;
  logic [_W-1:0] wr_dat_s;
  logic          rvalid_s;

  // State register and transaction latches, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdat_q       <= {_W{1'b0}};
      rdat_q       <= {_W{1'b0}};
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      err_q        <= err_d;
    end
  end

  // Next-state, arbitration and per-state strobe decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    err_d        = err_q;
    grant_s      = 1'b0;
    any_valid_s  = 1'b0;
    sel_addr_s   = 32'd0;
    ready0_s     = 1'b0;
    ready1_s     = 1'b0;
    rd_en_s      = 1'b0;
    wr_en_s      = 1'b0;
    rd_addr_s    = 32'd0;
    wr_addr_s    = 32'd0;
    wr_dat_s     = {_W{1'b0}};
    rvalid_s     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (p0_valid && p1_valid) begin
          grant_s = ~last_grant_q;
        end else if (p1_valid) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        any_valid_s = p0_valid | p1_valid;
        sel_addr_s  = grant_s ? p1_addr : p0_addr;
        if (any_valid_s) begin
          ready0_s     = ~grant_s;
          ready1_s     = grant_s;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          we_d         = grant_s ? p1_we : p0_we;
          addr_d       = sel_addr_s;
          wdat_d       = grant_s ? p1_wdat : p0_wdat;
          rdat_d       = {_W{1'b0}};
          if ({1'b0, sel_addr_s} >= ADDR_LIMIT) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          wr_en_s   = 1'b1;
          wr_addr_s = addr_q;
          wr_dat_s  = wdat_q;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = addr_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        // A failed read returns zero data alongside the error flag.
        if (we_q) begin
          rdat_d = {_W{1'b0}};
          err_d  = ~mem_w_v;
        end else begin
          rdat_d = mem_r_v ? mem_read_dat : {_W{1'b0}};
          err_d  = ~mem_r_v;
        end
        state_d = RESP;
      end
      RESP: begin
        rvalid_s = 1'b1;
        if (owner_q ? p1_rready : p0_rready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  assign p0_ready  = ready0_s & ~rst;
  assign p1_ready  = ready1_s & ~rst;
  assign p0_rvalid = rvalid_s & ~owner_q & ~rst;
  assign p1_rvalid = rvalid_s & owner_q & ~rst;
  assign p0_rdat   = p0_rvalid ? rdat_q : {_W{1'b0}};
  assign p1_rdat   = p1_rvalid ? rdat_q : {_W{1'b0}};
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;

  assign mem_read_en    = rd_en_s & ~rst;
  assign mem_write_en   = wr_en_s & ~rst;
  assign mem_read_addr  = rst ? 32'd0 : rd_addr_s;
  assign mem_write_addr = rst ? 32'd0 : wr_addr_s;
  assign mem_write_dat  = rst ? {_W{1'b0}} : wr_dat_s;

endmodule
